// File: rtl/fetch_unit.sv
// Instruction fetch unit with a small prefetch queue in front of the decoder.
// Latency: request in cycle N, instruction visible at the queue head in cycle N+2.
// Backpressure: credit-gated fetch (queued + in-flight < QUEUE_DEPTH); head held while inst_ready_in is low.
//
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   imem_addr_out/_req_out - fetch request to instruction memory
//   imem_data_in           - instruction data, valid the cycle after its request
//   redirect_in/_pc_in     - branch/jump redirect; flushes the queue and any in-flight return
//   inst_out/_pc_out       - queue head instruction and its PC (zero when empty)
//   inst_valid_out         - head valid; transfers when inst_ready_in is also high
//   count_out              - registered number of valid queue entries
//
// QUEUE_DEPTH must be a power of two (>= 2) so the head/tail pointers wrap naturally.

module fetch_unit #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h00400000),
    parameter int                PC_STEP     = 4,
    parameter int                QUEUE_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic [ADDR_W-1:0]                  imem_addr_out,
    output logic                               imem_req_out,
    input  logic [31:0]                        imem_data_in,
    input  logic                               redirect_in,
    input  logic [ADDR_W-1:0]                  redirect_pc_in,
    output logic [31:0]                        inst_out,
    output logic [ADDR_W-1:0]                  inst_pc_out,
    output logic                               inst_valid_out,
    input  logic                               inst_ready_in,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count_out
);

    localparam int                PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int                CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_C   = ~(ADDR_W'(PC_STEP - 1));

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0]       inst_mem_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [QUEUE_DEPTH];

    logic [CNT_W:0]    credit_used;
    logic              req;
    logic              head_vld;
    logic              push;
    logic              pop;
    logic              wr_en;

    always_comb begin
        // The in-flight request already owns a slot, so it is charged against the credit.
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        req         = !reset && !redirect_in && (credit_used < DEPTH_C);
        head_vld    = (count_q != '0);
        pop         = head_vld && !reset && inst_ready_in;
        // Memory data arrives exactly one cycle after the request, i.e. whenever a request was in flight.
        push        = inflight_q;
        wr_en       = push && !redirect_in && !reset;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (redirect_in) begin
            // Flush: drop queue contents and the returning data; refetch from the aligned target.
            fetch_pc_d = redirect_pc_in & ALIGN_C;
            inflight_d = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (req) begin
                fetch_pc_d    = fetch_pc_q + STEP_C;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage needs no reset: outputs are masked to zero whenever the queue is empty.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            inst_mem_q[tail_q] <= imem_data_in;
            pc_mem_q[tail_q]   <= inflight_pc_q;
        end
    end

    always_comb begin
        imem_addr_out  = fetch_pc_q;
        imem_req_out   = req;
        inst_valid_out = head_vld && !reset;
        inst_out       = inst_valid_out ? inst_mem_q[head_q] : '0;
        inst_pc_out    = inst_valid_out ? pc_mem_q[head_q]   : '0;
        count_out      = count_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset release, streaming, backpressure, redirect flushes, PC wrap, reset mid-run.
// Memory model returns addr ^ 32'hA5A5A5A5 one cycle after each request.
// Inputs driven 1 time unit after the rising edge; outputs checked 3 units after the edge.

module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr_out;
    logic        imem_req_out;
    logic [31:0] imem_data_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_valid_out;
    logic        inst_ready_in;
    logic [2:0]  count_out;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr_out  (imem_addr_out),
        .imem_req_out   (imem_req_out),
        .imem_data_in   (imem_data_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .inst_out       (inst_out),
        .inst_pc_out    (inst_pc_out),
        .inst_valid_out (inst_valid_out),
        .inst_ready_in  (inst_ready_in),
        .count_out      (count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: data for the address requested last cycle.
    logic [31:0] mem_addr_q = 32'h0;
    always @(posedge clock) begin
        if (imem_req_out) mem_addr_q <= imem_addr_out;
    end
    assign imem_data_in = mem_addr_q ^ 32'hA5A5A5A5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        inst_ready_in  = 1'b1;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'h0;

        // Reset state
        repeat (3) tick();
        #2;
        chk("rst_req",  imem_req_out,   0);
        chk("rst_vld",  inst_valid_out, 0);
        chk("rst_cnt",  count_out,      0);
        chk("rst_inst", inst_out,       0);
        chk("rst_pc",   inst_pc_out,    0);

        // Reset release, consumer always ready
        tick(); reset = 1'b0; #2;
        chk("c0_req",  imem_req_out,   1);
        chk("c0_addr", imem_addr_out,  32'h00400000);
        chk("c0_vld",  inst_valid_out, 0);
        tick(); #2;
        chk("c1_addr", imem_addr_out,  32'h00400004);
        chk("c1_vld",  inst_valid_out, 0);
        tick(); #2;
        chk("c2_vld",  inst_valid_out, 1);
        chk("c2_pc",   inst_pc_out,    32'h00400000);
        chk("c2_inst", inst_out,       32'hA5E5A5A5);
        chk("c2_cnt",  count_out,      1);
        tick(); #2;
        chk("c3_pc",   inst_pc_out,    32'h00400004);
        chk("c3_inst", inst_out,       32'hA5E5A5A1);
        chk("c3_cnt",  count_out,      1);
        tick(); #2;
        chk("c4_pc",   inst_pc_out,    32'h00400008);
        chk("c4_inst", inst_out,       32'hA5E5A5AD);

        // Backpressure: consumer stalled from reset release
        tick(); reset = 1'b1; inst_ready_in = 1'b0;
        tick(); reset = 1'b0; #2;
        chk("bp_c0_addr", imem_addr_out, 32'h00400000);
        tick(); tick(); #2;
        chk("bp_c2_pc",  inst_pc_out,  32'h00400000);
        tick(); tick(); #2;
        chk("bp_c4_req", imem_req_out, 0);
        chk("bp_c4_cnt", count_out,    3);
        tick(); #2;
        chk("bp_c5_cnt",  count_out,      4);
        chk("bp_c5_req",  imem_req_out,   0);
        chk("bp_c5_vld",  inst_valid_out, 1);
        chk("bp_c5_pc",   inst_pc_out,    32'h00400000);
        chk("bp_c5_inst", inst_out,       32'hA5E5A5A5);
        repeat (3) tick();
        #2;
        chk("bp_c8_cnt",  count_out,    4);
        chk("bp_c8_req",  imem_req_out, 0);
        chk("bp_c8_pc",   inst_pc_out,  32'h00400000);
        chk("bp_c8_inst", inst_out,     32'hA5E5A5A5);

        // Redirect from a full queue to an unaligned target
        tick(); redirect_in = 1'b1; redirect_pc_in = 32'h00400103; #2;
        chk("rf_t_req", imem_req_out, 0);
        tick(); redirect_in = 1'b0; #2;
        chk("rf_t1_cnt",  count_out,      0);
        chk("rf_t1_vld",  inst_valid_out, 0);
        chk("rf_t1_req",  imem_req_out,   1);
        chk("rf_t1_addr", imem_addr_out,  32'h00400100);
        tick(); #2;
        chk("rf_t2_vld",  inst_valid_out, 0);
        tick(); inst_ready_in = 1'b1; #2;
        chk("rf_t3_vld",  inst_valid_out, 1);
        chk("rf_t3_pc",   inst_pc_out,    32'h00400100);
        chk("rf_t3_inst", inst_out,       32'hA5E5A4A5);

        // Redirect together with a pop of 0x00400104 and the return of 0x00400108
        tick(); redirect_in = 1'b1; redirect_pc_in = 32'h00400200; #2;
        chk("rp_t_vld", inst_valid_out, 1);
        chk("rp_t_pc",  inst_pc_out,    32'h00400104);
        chk("rp_t_req", imem_req_out,   0);
        tick(); redirect_in = 1'b0; #2;
        chk("rp_t1_cnt",  count_out,      0);
        chk("rp_t1_vld",  inst_valid_out, 0);
        chk("rp_t1_addr", imem_addr_out,  32'h00400200);
        tick(); #2;
        chk("rp_t2_vld",  inst_valid_out, 0);
        tick(); #2;
        chk("rp_t3_pc",   inst_pc_out,    32'h00400200);
        chk("rp_t3_inst", inst_out,       32'hA5E5A7A5);
        tick(); #2;
        chk("rp_t4_pc",   inst_pc_out,    32'h00400204);

        // PC wrap at the top of the address space
        tick(); redirect_in = 1'b1; redirect_pc_in = 32'hFFFFFFFC;
        tick(); redirect_in = 1'b0; #2;
        chk("wr_t1_addr", imem_addr_out, 32'hFFFFFFFC);
        tick(); #2;
        chk("wr_t2_addr", imem_addr_out, 32'h00000000);
        tick(); #2;
        chk("wr_t3_pc",   inst_pc_out,   32'hFFFFFFFC);
        chk("wr_t3_inst", inst_out,      32'h5A5A5A59);
        tick(); #2;
        chk("wr_t4_pc",   inst_pc_out,   32'h00000000);
        chk("wr_t4_inst", inst_out,      32'hA5A5A5A5);

        // Reset (coinciding with a redirect) while three entries are queued
        tick(); inst_ready_in = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h00400300;
        tick(); redirect_in = 1'b0;
        repeat (4) tick();
        #2;
        chk("rs_pre_cnt", count_out, 3);
        reset = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h00500000; #2;
        chk("rs_in_req", imem_req_out,   0);
        chk("rs_in_vld", inst_valid_out, 0);
        tick(); reset = 1'b0; redirect_in = 1'b0; #2;
        chk("rs_c0_cnt",  count_out,      0);
        chk("rs_c0_vld",  inst_valid_out, 0);
        chk("rs_c0_req",  imem_req_out,   1);
        chk("rs_c0_addr", imem_addr_out,  32'h00400000);
        tick(); tick(); #2;
        chk("rs_c2_pc",   inst_pc_out,    32'h00400000);
        chk("rs_c2_inst", inst_out,       32'hA5E5A5A5);
        chk("rs_c2_cnt",  count_out,      1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC and instruction-memory address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h00400000, meaning the first fetch address after reset.
REQ-003 SHALL have parameter PC_STEP, default 4, meaning the sequential PC increment in bytes.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4, meaning prefetch queue entries; power of two, minimum 2.
REQ-005 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-007 SHALL have port imem_addr_out, output, ADDR_W, meaning the fetch address presented to instruction memory.
REQ-008 SHALL have port imem_req_out, output, 1, meaning imem_addr_out is a valid request this cycle.
REQ-009 SHALL have port imem_data_in, input, 32, meaning instruction data, valid exactly one cycle after its request.
REQ-010 SHALL have ports redirect_in (input, 1) and redirect_pc_in (input, ADDR_W), meaning a branch/jump redirect and its target.
REQ-011 SHALL have port inst_out, output, 32, meaning the instruction at the queue head.
REQ-012 SHALL have port inst_pc_out, output, ADDR_W, meaning the PC of inst_out.
REQ-013 SHALL have port inst_valid_out, output, 1, meaning the queue head is valid.
REQ-014 SHALL have port inst_ready_in, input, 1, meaning the consumer accepts the head this cycle.
REQ-015 SHALL have port count_out, output, clog2(QUEUE_DEPTH+1), meaning the number of valid queue entries.

Function
REQ-016 SHALL hold a fetch PC register; each issued request presents fetch_pc and advances it by PC_STEP, modulo 2^ADDR_W, so all-ones minus 3 wraps to 0.
REQ-017 SHALL issue a request only when count plus in-flight requests is less than QUEUE_DEPTH (credit rule); the queue never overflows.
REQ-018 SHALL have at most one request in flight; returning data is pushed with its PC at the end of the return cycle.
REQ-019 SHALL give a fetch-to-output latency of 2 cycles: request in cycle N, entry visible on inst_valid_out in cycle N+2.
REQ-020 SHALL treat a head transfer as occurring when inst_valid_out and inst_ready_in are both high; the head then retires.
REQ-021 SHALL hold inst_out, inst_pc_out and inst_valid_out stable while inst_valid_out is high and inst_ready_in is low.
REQ-022 SHALL leave count unchanged on a simultaneous push and pop, including when full.
REQ-023 SHALL, on redirect_in in cycle T, empty the queue, squash any in-flight return, issue no request in T, and set fetch_pc to redirect_pc_in with the low log2(PC_STEP) bits cleared.
REQ-024 SHALL issue the first request at the target in cycle T+1, with the target valid at the output in cycle T+3.
REQ-025 SHALL give redirect priority when it coincides with a pop or push; the pop and push are discarded.
REQ-026 SHALL report count_out as the registered entry count, 0 to QUEUE_DEPTH.
REQ-027 SHALL keep inst_out and inst_pc_out equal to zero when the queue is empty.

Reset
REQ-028 SHALL, while reset is high, set fetch_pc=RESET_PC, count=0, in-flight=0, imem_req_out=0, inst_valid_out=0, inst_out=0 and inst_pc_out=0.
REQ-029 SHALL, on reset asserted mid-operation, discard queued and in-flight data; reset overrides redirect.
REQ-030 SHALL issue the first request at RESET_PC in the first cycle after reset deasserts.

Verification
REQ-031 SHALL cover reset release with inst_ready_in=1 and memory returning addr^32'hA5A5A5A5: PCs 0x00400000, 0x00400004, 0x00400008 appear one per cycle from cycle 2 after release.
REQ-032 SHALL cover backpressure with inst_ready_in=0: count_out saturates at 4, requests stop, and the head stays PC 0x00400000 with unchanged data.
REQ-033 SHALL cover a full queue with redirect_pc_in=0x00400103: the queue empties next cycle, the next request is 0x00400100, and it is the first valid output 3 cycles after the redirect.
REQ-034 SHALL cover redirect coinciding with a pop and an in-flight return: the popped entry is not repeated, the returned data never appears, and count_out=0 the next cycle.
REQ-035 SHALL cover wrap with redirect to 0xFFFFFFFC: output PCs are 0xFFFFFFFC then 0x00000000.
REQ-036 SHALL cover reset asserted with 3 entries queued: the next cycle has count_out=0 and inst_valid_out=0, and fetch restarts at 0x00400000.
